// File: rtl/spi_slave_if.sv
// Bus-side signal bundle of spi_slave: SPI pins, control/status registers and TX/RX data.
interface spi_slave_if #(
  parameter int unsigned DATA = 32
);
  logic            sclk;
  logic            ss;
  logic            mosi;
  logic            miso;
  logic            miso_oe;
  logic [7:0]      SPICR_1;
  logic [DATA-1:0] SWDATA;
  logic            tx_load;
  logic            rx_ack;
  logic [DATA-1:0] SRDATA;
  logic [7:0]      SPISR;
  logic            irq;

  modport slave (
    input  sclk, ss, mosi, SPICR_1, SWDATA, tx_load, rx_ack,
    output miso, miso_oe, SRDATA, SPISR, irq
  );

  modport master (
    output sclk, ss, mosi, SPICR_1, SWDATA, tx_load, rx_ack,
    input  miso, miso_oe, SRDATA, SPISR, irq
  );
endinterface

// File: rtl/spi_slave.sv
// SPI target oversampled in the PCLK domain: shifts a DATA-bit word in on mosi and out on miso.
// Optional interrupt output enabled by defining SPI_SLAVE_IRQ_EN.
module spi_slave #(
  parameter int unsigned     DATA     = 32,
  parameter logic [DATA-1:0] IDLE_PAT = '0
) (
  input logic        PCLK,
  input logic        PRESETn,
  spi_slave_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DATA-1:0] tx_sr_q, tx_sr_d;
  logic [DATA-1:0] rx_sr_q, rx_sr_d;
  logic [DATA-1:0] tx_buf_q, tx_buf_d;
  logic [DATA-1:0] srdata_q, srdata_d;
  logic            miso_q, miso_d;
  logic            sptef_q, sptef_d;
  logic            spif_q, spif_d;
  logic            ovrf_q, ovrf_d;
  logic            abrt_q, abrt_d;
  logic            done_q, done_d;

  logic sclk_meta_q, sclk_q, sclk_prev_q;
  logic ss_meta_q, ss_q;
  logic mosi_meta_q, mosi_q;

  logic spe, cpol, cpha, lsbfe;
  logic sclk_chg, leading, trailing, sample_edge, shift_edge;
  logic [DATA-1:0] load_word;

  assign spe   = bus.SPICR_1[6];
  assign cpol  = bus.SPICR_1[3];
  assign cpha  = bus.SPICR_1[2];
  assign lsbfe = bus.SPICR_1[0];

  // ss resets high so the block comes up deselected.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_meta_q <= 1'b0;
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      ss_meta_q   <= 1'b1;
      ss_q        <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_meta_q <= bus.sclk;
      sclk_q      <= sclk_meta_q;
      sclk_prev_q <= sclk_q;
      ss_meta_q   <= bus.ss;
      ss_q        <= ss_meta_q;
      mosi_meta_q <= bus.mosi;
      mosi_q      <= mosi_meta_q;
    end
  end

  assign sclk_chg    = sclk_q != sclk_prev_q;
  assign leading     = sclk_chg && (sclk_prev_q == cpol);
  assign trailing    = sclk_chg && (sclk_q == cpol);
  assign sample_edge = cpha ? trailing : leading;
  assign shift_edge  = cpha ? leading : trailing;
  assign load_word   = sptef_q ? IDLE_PAT : tx_buf_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    tx_buf_d = tx_buf_q;
    srdata_d = srdata_q;
    miso_d   = miso_q;
    sptef_d  = sptef_q;
    spif_d   = spif_q;
    ovrf_d   = ovrf_q;
    abrt_d   = abrt_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (spe && !ss_q) state_d = StLoad;
      end
      StLoad: begin
        tx_sr_d = load_word;
        miso_d  = lsbfe ? load_word[0] : load_word[DATA-1];
        sptef_d = 1'b1;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (sample_edge) begin
          rx_sr_d = lsbfe ? {mosi_q, rx_sr_q[DATA-1:1]} : {rx_sr_q[DATA-2:0], mosi_q};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA - 1)) begin
            done_d  = 1'b1;
            state_d = StLoad;
          end
        end else if (shift_edge && cnt_q != '0) begin
          // A shift edge before any sample is either the CPHA=1 first edge or the previous
          // word's final CPHA=0 trailing edge; neither may advance the output.
          tx_sr_d = lsbfe ? (tx_sr_q >> 1) : (tx_sr_q << 1);
          miso_d  = lsbfe ? tx_sr_q[1] : tx_sr_q[DATA-2];
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.rx_ack) begin
      spif_d = 1'b0;
      ovrf_d = 1'b0;
      abrt_d = 1'b0;
    end

    if ((!spe || ss_q) && state_q != StIdle) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      cnt_d   = '0;
      if (cnt_q != '0 && cnt_q < CntW'(DATA)) abrt_d = 1'b1;
    end

    if (done_q) begin
      srdata_d = rx_sr_q;
      spif_d   = 1'b1;
      ovrf_d   = bus.rx_ack ? ovrf_q : (ovrf_q | spif_q);
    end

    if (bus.tx_load) begin
      tx_buf_d = bus.SWDATA;
      sptef_d  = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      tx_buf_q <= IDLE_PAT;
      srdata_q <= '0;
      miso_q   <= 1'b0;
      sptef_q  <= 1'b1;
      spif_q   <= 1'b0;
      ovrf_q   <= 1'b0;
      abrt_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      tx_buf_q <= tx_buf_d;
      srdata_q <= srdata_d;
      miso_q   <= miso_d;
      sptef_q  <= sptef_d;
      spif_q   <= spif_d;
      ovrf_q   <= ovrf_d;
      abrt_q   <= abrt_d;
      done_q   <= done_d;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.miso_oe = (state_q != StIdle) && spe;
  assign bus.SRDATA  = srdata_q;
  assign bus.SPISR   = {spif_q, 1'b0, sptef_q, ovrf_q, abrt_q, 3'b000};

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_q;
  logic unused_cr;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= spif_q | ovrf_q | abrt_q | (bus.SPICR_1[5] & sptef_q);
    end
  end

  assign bus.irq   = irq_q;
  assign unused_cr = ^{bus.SPICR_1[7], bus.SPICR_1[4], bus.SPICR_1[1]};
`else
  logic unused_cr;

  assign bus.irq   = 1'b0;
  assign unused_cr = ^{bus.SPICR_1[7], bus.SPICR_1[5], bus.SPICR_1[4], bus.SPICR_1[1]};
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives the pins; a monitor pops queued RX words
// whenever the DUT publishes a completed word, the master checks the word it read on miso.
module tb_spi_slave;
  localparam int unsigned DATA = 32;
  localparam int unsigned HALF = 5;

  logic PCLK = 1'b0;
  logic PRESETn;
  int   checks = 0;
  int   errors = 0;

  logic [DATA-1:0] exp_rx_q[$];
  logic [DATA-1:0] exp_miso_q[$];
  logic [DATA-1:0] prev_srdata = '0;
  logic            prev_spif = 1'b0;

  spi_slave_if #(.DATA(DATA)) bus ();

  spi_slave #(
    .DATA    (DATA),
    .IDLE_PAT(32'h0)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Completed word: SRDATA changes or SPIF rises (outside reset).
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1 && (bus.SRDATA !== prev_srdata || (bus.SPISR[7] && !prev_spif))) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected got=%h exp=none", bus.SRDATA);
      end else begin
        chk("rx_word", bus.SRDATA, exp_rx_q.pop_front());
      end
    end
    prev_srdata <= bus.SRDATA;
    prev_spif   <= bus.SPISR[7];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic half_period();
    repeat (HALF) @(posedge PCLK);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge PCLK);
    #1;
    bus.rx_ack = 1'b1;
    @(posedge PCLK);
    #1;
    bus.rx_ack = 1'b0;
  endtask

  task automatic preload(input logic [DATA-1:0] w);
    @(posedge PCLK);
    #1;
    bus.SWDATA  = w;
    bus.tx_load = 1'b1;
    @(posedge PCLK);
    #1;
    bus.tx_load = 1'b0;
  endtask

  task automatic set_mode(input logic [7:0] cr);
    bus.SPICR_1 = cr;
    bus.sclk    = cr[3];
    cycles(4);
  endtask

  // Master side of one word (or its first nbits); checks the word read on miso when complete.
  task automatic spi_xfer(input logic [DATA-1:0] tx, input int nbits, input bit keep_ss);
    logic            cpol, cpha, lsbfe;
    logic [DATA-1:0] rx;
    int              idx;
    cpol  = bus.SPICR_1[3];
    cpha  = bus.SPICR_1[2];
    lsbfe = bus.SPICR_1[0];
    rx    = '0;
    if (bus.ss) begin
      bus.ss = 1'b0;
      cycles(8);
    end
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe ? i : DATA - 1 - i;
      if (!cpha) begin
        bus.mosi = tx[idx];
        half_period();
        bus.sclk = ~cpol;
        rx[idx]  = bus.miso;
        half_period();
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = tx[idx];
        half_period();
        bus.sclk = cpol;
        rx[idx]  = bus.miso;
        half_period();
      end
    end
    if (nbits == DATA) chk("miso_word", rx, exp_miso_q.pop_front());
    if (!keep_ss) begin
      half_period();
      bus.ss = 1'b1;
    end
  endtask

  logic [7:0] modes [6] = '{8'h40, 8'h44, 8'h48, 8'h4C, 8'h41, 8'h4D};

  initial begin
    PRESETn     = 1'b0;
    bus.sclk    = 1'b0;
    bus.ss      = 1'b1;
    bus.mosi    = 1'b0;
    bus.SPICR_1 = 8'h40;
    bus.SWDATA  = '0;
    bus.tx_load = 1'b0;
    bus.rx_ack  = 1'b0;
    cycles(3);
    chk("rst_spisr", 32'(bus.SPISR), 32'h20);
    chk("rst_srdata", bus.SRDATA, 32'h0);
    chk("rst_miso", 32'(bus.miso), 32'h0);
    chk("rst_miso_oe", 32'(bus.miso_oe), 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    PRESETn = 1'b1;
    cycles(4);

    // Same words in every mode and bit order.
    foreach (modes[m]) begin
      set_mode(modes[m]);
      pulse_ack();
      preload(32'hA5A5_1234);
      chk("spisr_loaded", 32'(bus.SPISR), 32'h00);
      exp_rx_q.push_back(32'hDEAD_BEEF);
      exp_miso_q.push_back(32'hA5A5_1234);
      spi_xfer(32'hDEAD_BEEF, DATA, 1'b0);
      cycles(10);
      chk("spisr_done", 32'(bus.SPISR), 32'hA0);
      chk("miso_oe_idle", 32'(bus.miso_oe), 32'h0);
    end

    // Empty TX buffer sends IDLE_PAT.
    set_mode(8'h40);
    pulse_ack();
    chk("spisr_empty", 32'(bus.SPISR), 32'h20);
    exp_rx_q.push_back(32'h1357_9BDF);
    exp_miso_q.push_back(32'h0);
    spi_xfer(32'h1357_9BDF, DATA, 1'b0);
    cycles(10);
    chk("spisr_idlepat", 32'(bus.SPISR), 32'hA0);

    // Back-to-back words without rx_ack give overrun.
    pulse_ack();
    preload(32'h0F0F_F0F0);
    exp_rx_q.push_back(32'h1111_2222);
    exp_rx_q.push_back(32'h3333_4444);
    exp_miso_q.push_back(32'h0F0F_F0F0);
    exp_miso_q.push_back(32'h0);
    spi_xfer(32'h1111_2222, DATA, 1'b1);
    spi_xfer(32'h3333_4444, DATA, 1'b0);
    cycles(10);
    chk("spisr_ovrf", 32'(bus.SPISR), 32'hB0);
    pulse_ack();
    chk("spisr_acked", 32'(bus.SPISR), 32'h20);

    // Abort after 13 bits.
    spi_xfer(32'hFFFF_0000, 13, 1'b1);
    chk("miso_oe_active", 32'(bus.miso_oe), 32'h1);
    @(posedge PCLK);
    #1;
    bus.ss = 1'b1;
    cycles(3);
    chk("miso_oe_abort", 32'(bus.miso_oe), 32'h0);
    cycles(6);
    chk("spisr_abrt", 32'(bus.SPISR), 32'h28);
    chk("srdata_kept", bus.SRDATA, 32'h3333_4444);
    pulse_ack();
    chk("spisr_abrt_ack", 32'(bus.SPISR), 32'h20);

    // Reset mid-word, then a clean word.
    spi_xfer(32'h5555_AAAA, 10, 1'b1);
    PRESETn = 1'b0;
    cycles(1);
    chk("mid_rst_spisr", 32'(bus.SPISR), 32'h20);
    chk("mid_rst_srdata", bus.SRDATA, 32'h0);
    chk("mid_rst_miso", 32'(bus.miso), 32'h0);
    chk("mid_rst_miso_oe", 32'(bus.miso_oe), 32'h0);
    bus.ss   = 1'b1;
    bus.sclk = 1'b0;
    cycles(4);
    PRESETn = 1'b1;
    cycles(4);
    preload(32'h600D_D00D);
    exp_rx_q.push_back(32'hCAFE_F00D);
    exp_miso_q.push_back(32'h600D_D00D);
    spi_xfer(32'hCAFE_F00D, DATA, 1'b0);
    cycles(10);
    chk("spisr_post_rst", 32'(bus.SPISR), 32'hA0);

    cycles(20);
    chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
